// File: rtl/post_entry_tx_fsm.sv
// Post-entry message sequencer: sends BYTE0, BYTE1, BYTE2 through the UART
// load/empty handshake after a start request, then pulses done for one cycle.
module post_entry_tx_fsm #(
  parameter logic [7:0] BYTE0 = 8'h4F,
  parameter logic [7:0] BYTE1 = 8'h4B,
  parameter logic [7:0] BYTE2 = 8'h0A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       txempty,
  output logic       done,
  output logic [7:0] txdata,
  output logic       ldtxdata,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_LOAD0     = 4'd1,
    S_WAITLOAD0 = 4'd2,
    S_WAITSEND0 = 4'd3,
    S_LOAD1     = 4'd4,
    S_WAITLOAD1 = 4'd5,
    S_WAITSEND1 = 4'd6,
    S_LOAD2     = 4'd7,
    S_WAITLOAD2 = 4'd8,
    S_WAITSEND2 = 4'd9,
    S_FINISH    = 4'd10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FINISH);
    end
  end

  // Handshake: ldtxdata is a one-cycle strobe that hands txdata to the UART;
  // txempty=1 means the UART can take the next byte and is only honoured in
  // WAITSENDn. WAITLOADn gives the UART one cycle to drop txempty after a load.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:      if (start) w_next = S_LOAD0;
      S_LOAD0:     w_next = S_WAITLOAD0;
      S_WAITLOAD0: w_next = S_WAITSEND0;
      S_WAITSEND0: if (txempty) w_next = S_LOAD1;
      S_LOAD1:     w_next = S_WAITLOAD1;
      S_WAITLOAD1: w_next = S_WAITSEND1;
      S_WAITSEND1: if (txempty) w_next = S_LOAD2;
      S_LOAD2:     w_next = S_WAITLOAD2;
      S_WAITLOAD2: w_next = S_WAITSEND2;
      S_WAITSEND2: if (txempty) w_next = S_FINISH;
      S_FINISH:    w_next = S_INIT;
      default:     w_next = S_INIT;
    endcase
  end

  always_comb begin
    ldtxdata = 1'b0;
    txdata   = 8'h00;
    case (r_state)
      S_LOAD0:     begin ldtxdata = 1'b1; txdata = BYTE0; end
      S_WAITLOAD0,
      S_WAITSEND0: txdata = BYTE0;
      S_LOAD1:     begin ldtxdata = 1'b1; txdata = BYTE1; end
      S_WAITLOAD1,
      S_WAITSEND1: txdata = BYTE1;
      S_LOAD2:     begin ldtxdata = 1'b1; txdata = BYTE2; end
      S_WAITLOAD2,
      S_WAITSEND2: txdata = BYTE2;
      default:     ;
    endcase
  end

  assign done    = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_post_entry_tx_fsm.sv
// Bench for post_entry_tx_fsm: directed stimulus pushes expected bytes/done
// events into a queue; a negedge monitor pops and compares them.
module tb_post_entry_tx_fsm;

  localparam logic [3:0] ST_INIT      = 4'd0;
  localparam logic [3:0] ST_LOAD0     = 4'd1;
  localparam logic [3:0] ST_WAITLOAD0 = 4'd2;
  localparam logic [3:0] ST_WAITSEND0 = 4'd3;
  localparam logic [3:0] ST_LOAD1     = 4'd4;
  localparam logic [3:0] ST_WAITLOAD1 = 4'd5;
  localparam logic [3:0] ST_WAITSEND1 = 4'd6;
  localparam logic [3:0] ST_LOAD2     = 4'd7;
  localparam logic [3:0] ST_WAITLOAD2 = 4'd8;
  localparam logic [3:0] ST_WAITSEND2 = 4'd9;
  localparam logic [3:0] ST_FINISH    = 4'd10;
  localparam logic [8:0] EV_DONE      = 9'h100;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       txempty;
  logic       done;
  logic [7:0] txdata;
  logic       ldtxdata;
  logic [3:0] o_state;

  logic [8:0] exp_q[$];
  int checks;
  int errors;

  post_entry_tx_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .txempty  (txempty),
    .done     (done),
    .txdata   (txdata),
    .ldtxdata (ldtxdata),
    .o_state  (o_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_msg();
    exp_q.push_back({1'b0, 8'h4F});
    exp_q.push_back({1'b0, 8'h4B});
    exp_q.push_back({1'b0, 8'h0A});
    exp_q.push_back(EV_DONE);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (ldtxdata || done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: ld=%0b done=%0b txdata=%0h with nothing expected",
                 ldtxdata, done, txdata);
      end else begin
        logic [8:0] e;
        logic [8:0] a;
        e = exp_q.pop_front();
        a = done ? EV_DONE : {1'b0, txdata};
        if (a !== e) begin
          errors++;
          $display("FAIL mon_event: got %0h expected %0h", a, e);
        end
        if (done && o_state != ST_INIT) begin
          errors++;
          $display("FAIL mon_done_state: got %0d expected %0d", o_state, ST_INIT);
        end
      end
    end
  end

  initial begin
    int n;
    int lds;
    bit seen;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    txempty = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // reset / idle
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_state", 16'(o_state), 16'(ST_INIT));
      chk("idle_outs", {6'd0, done, ldtxdata, txdata}, 16'h0000);
    end

    // step-through with txempty=0, then one-cycle txempty handoffs
    push_msg();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("step_load0", {o_state, 3'd0, ldtxdata, txdata}, {ST_LOAD0, 3'd0, 1'b1, 8'h4F});
    tick();
    chk("step_wl0", {o_state, 3'd0, ldtxdata, txdata}, {ST_WAITLOAD0, 3'd0, 1'b0, 8'h4F});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("step_ws0", {o_state, 3'd0, ldtxdata, txdata}, {ST_WAITSEND0, 3'd0, 1'b0, 8'h4F});
    end
    txempty = 1'b1;
    tick();
    txempty = 1'b0;
    chk("step_load1", {o_state, 3'd0, ldtxdata, txdata}, {ST_LOAD1, 3'd0, 1'b1, 8'h4B});
    tick();
    chk("step_wl1", 16'(o_state), 16'(ST_WAITLOAD1));
    tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("step_ws1_start_ignored", {o_state, 3'd0, ldtxdata, txdata}, {ST_WAITSEND1, 3'd0, 1'b0, 8'h4B});
    txempty = 1'b1;
    tick();
    txempty = 1'b0;
    chk("step_load2", {o_state, 3'd0, ldtxdata, txdata}, {ST_LOAD2, 3'd0, 1'b1, 8'h0A});
    tick();
    chk("step_wl2", 16'(o_state), 16'(ST_WAITLOAD2));
    tick();
    chk("step_ws2", 16'(o_state), 16'(ST_WAITSEND2));
    txempty = 1'b1;
    tick();
    txempty = 1'b0;
    chk("step_finish", {o_state, 3'd0, done, txdata}, {ST_FINISH, 3'd0, 1'b0, 8'h00});
    tick();
    chk("step_done", {o_state, 3'd0, done, txdata}, {ST_INIT, 3'd0, 1'b1, 8'h00});
    tick();
    chk("step_done_clr", 16'(done), 16'd0);
    repeat (3) tick();

    // full run with txempty tied high; restart in the done cycle
    txempty = 1'b1;
    push_msg();
    start = 1'b1;
    n = 0; lds = 0; seen = 1'b0;
    while (n < 30 && !seen) begin
      tick();
      start = 1'b0;
      n++;
      if (ldtxdata) lds++;
      if (done) seen = 1'b1;
    end
    chk("full_seen_done", 16'(seen), 16'd1);
    chk("full_latency", 16'(n), 16'd11);
    chk("full_ld_count", 16'(lds), 16'd3);
    chk("full_done_state", 16'(o_state), 16'(ST_INIT));
    push_msg();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_load0", {o_state, 3'd0, done, txdata}, {ST_LOAD0, 3'd0, 1'b0, 8'h4F});
    n = 1; seen = 1'b0;
    while (n < 30 && !seen) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    chk("restart_latency", 16'(n), 16'd11);
    txempty = 1'b0;
    repeat (3) tick();

    // txempty toggling every cycle
    push_msg();
    start = 1'b1;
    n = 0; lds = 0; seen = 1'b0;
    while (n < 60 && !seen) begin
      tick();
      start = 1'b0;
      txempty = ~txempty;
      n++;
      if (ldtxdata) lds++;
      if (done) seen = 1'b1;
    end
    txempty = 1'b0;
    chk("toggle_seen_done", 16'(seen), 16'd1);
    chk("toggle_ld_count", 16'(lds), 16'd3);
    repeat (3) tick();

    // async abort in WAITSEND1
    exp_q.push_back({1'b0, 8'h4F});
    exp_q.push_back({1'b0, 8'h4B});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    txempty = 1'b1;
    tick();
    txempty = 1'b0;
    tick();
    tick();
    chk("abort_pre_state", 16'(o_state), 16'(ST_WAITSEND1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 16'(o_state), 16'(ST_INIT));
    chk("abort_outs", {6'd0, done, ldtxdata, txdata}, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    txempty = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("abort_no_done", {o_state, 3'd0, done, 8'h00}, {ST_INIT, 12'h000});
    end
    txempty = 1'b0;

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/post_entry_tx_fsm.md
Name: post_entry_tx_fsm

Overview:
- Sequencer that, after an entry event, transmits a fixed 3-byte message through the UART transmitter's load/empty handshake.
- On a `start` request it presents each byte on `txdata` and pulses `ldtxdata`, then waits for `txempty` before the next byte.
- Pulses `done` when the message is complete.
- Sits between the security-system control FSM, which drives `start`/`done`, and the UART TX block, which drives `txempty`.

Parameters:
- BYTE0, 8'h4F, first byte transmitted ('O').
- BYTE1, 8'h4B, second byte transmitted ('K').
- BYTE2, 8'h0A, third byte transmitted (line feed).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to send the message; sampled only in INIT.
- txempty  input  1  UART TX holding register empty / ready for the next byte.
- done  output  1  one-cycle pulse: message fully handed to the UART.
- txdata  output  8  byte presented to the UART.
- ldtxdata  output  1  one-cycle load strobe for `txdata` into the UART.

Behaviour:
- States: INIT, LOAD0, WAITLOAD0, WAITSEND0, LOAD1, WAITLOAD1, WAITSEND1, LOAD2, WAITLOAD2, WAITSEND2, FINISH.
- Reset (rst_n=0, async): state=INIT, done=0, ldtxdata=0, txdata=8'h00. Reset mid-message aborts the message immediately; no `done` is produced.
- Transitions (per rising edge):
  - INIT -> LOAD0 if start=1, else stay in INIT.
  - LOADn -> WAITLOADn, unconditional.
  - WAITLOADn -> WAITSENDn, unconditional. This one-cycle guard lets the UART drop `txempty` after the load.
  - WAITSENDn stays while txempty=0.
  - On txempty=1: WAITSEND0 -> LOAD1, WAITSEND1 -> LOAD2, WAITSEND2 -> FINISH.
  - FINISH -> INIT, unconditional.
- `txempty` is ignored in every state except WAITSENDn.
- `start` is ignored outside INIT; no re-trigger or queueing.
- Outputs are decoded from the current state register (Moore):
  - ldtxdata=1 only in LOAD0/LOAD1/LOAD2.
  - txdata=BYTEn in LOADn, WAITLOADn and WAITSENDn; 8'h00 in INIT and FINISH.
- done is a flop:
  - Set on the FINISH->INIT edge, so done=1 during the first INIT cycle after FINISH.
  - Cleared on the next edge.
  - When done is observed high, state is already INIT.
- start=1 in that same INIT cycle launches a new message (INIT -> LOAD0); done still pulses for exactly one cycle.
- Latency with txempty held 1:
  - Edges 1..9 (counting from the edge that samples start=1) visit LOAD0, WAITLOAD0, WAITSEND0, LOAD1, WAITLOAD1, WAITSEND1, LOAD2, WAITLOAD2, WAITSEND2.
  - Edge 10 enters FINISH.
  - Edge 11 enters INIT with done=1.
  - Edge 12 clears done.
- Each LOADn lasts exactly one cycle, so each byte gets exactly one ldtxdata pulse, even if txempty stays 1.

Test Plan:
- Reset/idle: assert rst_n=0 then release, start=0 for 5 cycles -> state INIT, done=0, ldtxdata=0, txdata=8'h00 throughout.
- Step-through with txempty=0: pulse start for one cycle.
  - Expect LOAD0 (ldtxdata=1, txdata=8'h4F), then WAITLOAD0, then WAITSEND0.
  - Expect it to hold in WAITSEND0 for 2+ cycles with ldtxdata=0.
- Byte handoff: pulse txempty=1 for one cycle in WAITSENDn.
  - Expect LOAD1 (txdata=8'h4B), and later LOAD2 (txdata=8'h0A).
  - After WAITSEND2, expect FINISH, then INIT with done=1 for exactly 1 cycle.
- Full run with txempty tied 1: one-cycle start -> exactly 3 ldtxdata pulses with bytes 4F, 4B, 0A in order; done high 11 edges after the start edge, with state==INIT at that moment.
- Ignored inputs:
  - start=1 while in WAITSEND1 -> no effect.
  - txempty toggling during LOADn/WAITLOADn -> no skipped or duplicated bytes.
- Async abort: drive rst_n=0 mid-cycle while in WAITSEND1 -> immediate INIT, outputs zero, no done pulse.
